// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, legality and latency helpers, FSM states.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_AND) || (op == OP_OR)  || (op == OP_ADD) ||
             (op == OP_DIV) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

   function automatic int op_latency(input logic [3:0] op, input int mul_lat, input int div_lat);
      if (op == OP_MUL) return mul_lat;
      if (op == OP_DIV) return div_lat;
      return 1;
   endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, ptr names the requester favoured on a tie.
module alu_rr_arb (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   assign grant[0] = valid[0] & (~valid[1] | ~ptr);
   assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/alu_sched.sv
// Two-requester scheduler for a shared multi-cycle ALU; resolves div-by-zero and illegal ops locally
// and returns one tagged response at a time over valid/ready.
module alu_sched
   import alu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_ctrl,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_ctrl,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_overflow,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic [WIDTH-1:0] resp_r,
   output logic             resp_zero,
   output logic             resp_overflow,
   output logic             resp_err,
   output logic             busy
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   state_t           state, state_nxt;
   logic             ptr;
   logic [CW-1:0]    cnt;
   logic [1:0]       grant;
   logic             gid;
   logic             take;
   logic [3:0]       sel_ctrl;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             sel_legal, sel_divz;

   alu_rr_arb u_arb (
      .valid ({req1_valid, req0_valid}),
      .ptr   (ptr),
      .grant (grant)
   );

   assign gid       = grant[1];
   assign sel_ctrl  = gid ? req1_ctrl : req0_ctrl;
   assign sel_a     = gid ? req1_a : req0_a;
   assign sel_b     = gid ? req1_b : req0_b;
   assign sel_legal = is_legal_op(sel_ctrl);
   assign sel_divz  = (sel_ctrl == OP_DIV) && (sel_b == '0);

   always_comb begin
      state_nxt  = state;
      take       = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            if (|grant) begin
               take      = 1'b1;
               state_nxt = (sel_legal && !sel_divz) ? ST_EXEC : ST_RESP;
            end
         end
         ST_EXEC: begin
            if (cnt == CW'(1)) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr           <= 1'b0;
         cnt           <= '0;
         alu_ctrl      <= '0;
         alu_in1       <= '0;
         alu_in2       <= '0;
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_r        <= '0;
         resp_zero     <= 1'b0;
         resp_overflow <= 1'b0;
         resp_err      <= 1'b0;
      end else if (take) begin
         ptr     <= ~gid;
         resp_id <= gid;
         if (sel_legal && !sel_divz) begin
            alu_ctrl <= sel_ctrl;
            alu_in1  <= sel_a;
            alu_in2  <= sel_b;
            cnt      <= CW'(op_latency(sel_ctrl, MUL_LAT, DIV_LAT));
         end else if (sel_divz) begin
            resp_result   <= '1;
            resp_r        <= sel_a;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
            resp_err      <= 1'b1;
         end else begin
            resp_result   <= '0;
            resp_r        <= '0;
            resp_zero     <= 1'b1;
            resp_overflow <= 1'b0;
            resp_err      <= 1'b1;
         end
      end else if (state == ST_EXEC) begin
         cnt <= cnt - CW'(1);
         // ALU outputs are valid in the last cycle of the op's latency window
         if (cnt == CW'(1)) begin
            resp_result   <= alu_result;
            resp_r        <= (alu_ctrl == OP_DIV) ? alu_r : '0;
            resp_zero     <= (alu_result == '0);
            resp_overflow <= alu_overflow;
            resp_err      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched; the bench also plays the role of the ALU.
module tb_alu_sched;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_ctrl, req1_ctrl;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] alu_in1, alu_in2, alu_result, alu_r;
   logic         alu_overflow;
   logic         resp_valid, resp_ready, resp_id;
   logic [W-1:0] resp_result, resp_r;
   logic         resp_zero, resp_overflow, resp_err, busy;

   int errors = 0;
   int checks = 0;
   logic stale;

   always #5 clk = ~clk;

   alu_sched #(.WIDTH(W), .MUL_LAT(4), .DIV_LAT(16)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .alu_r(alu_r), .alu_overflow(alu_overflow),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_r(resp_r), .resp_zero(resp_zero),
      .resp_overflow(resp_overflow), .resp_err(resp_err), .busy(busy)
   );

   // Behavioural ALU; non-divide remainder is junk so the scheduler must mask it.
   always_comb begin
      alu_result   = '0;
      alu_r        = alu_in1 ^ 64'hDEAD;
      alu_overflow = 1'b0;
      case (alu_ctrl)
         4'b0010: alu_result = alu_in1 + alu_in2;
         4'b0110: alu_result = alu_in1 - alu_in2;
         4'b0111: alu_result = alu_in1 * alu_in2;
         4'b0000: alu_result = alu_in1 & alu_in2;
         4'b0001: alu_result = alu_in1 | alu_in2;
         4'b0100: begin
            alu_r = '0;
            if (alu_in2 != '0) begin
               alu_result = alu_in1 / alu_in2;
               alu_r      = alu_in1 % alu_in2;
            end
         end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int n, input logic v, input logic [3:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (n == 0) begin
         req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      resp_ready = 1'b1;
      set_req(0, 1'b0, 4'h0, '0, '0);
      set_req(1, 1'b0, 4'h0, '0, '0);
      do_reset();

      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_alu_ctrl", alu_ctrl, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_resp_result", resp_result, 0);

      // ADD 5+7 from req0
      set_req(0, 1'b1, 4'b0010, 5, 7);
      #1;
      chk("add_ready0", req0_ready, 1);
      chk("add_ready1", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      chk("add_alu_ctrl", alu_ctrl, 4'b0010);
      chk("add_alu_in1", alu_in1, 5);
      chk("add_t1_valid", resp_valid, 0);
      step();
      chk("add_t2_valid", resp_valid, 1);
      chk("add_result", resp_result, 12);
      chk("add_id", resp_id, 0);
      chk("add_zero", resp_zero, 0);
      chk("add_err", resp_err, 0);
      chk("add_r", resp_r, 0);
      step();
      chk("add_valid_drop", resp_valid, 0);

      // Simultaneous requests after reset: req0 first, then req1
      do_reset();
      set_req(0, 1'b1, 4'b0110, 10, 10);
      set_req(1, 1'b1, 4'b0001, 3, 4);
      #1;
      chk("rr_ready0", req0_ready, 1);
      chk("rr_ready1", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      chk("rr_exec_ready1", req1_ready, 0);
      step();
      chk("sub_result", resp_result, 0);
      chk("sub_zero", resp_zero, 1);
      chk("sub_id", resp_id, 0);
      step();
      chk("rr_ready1_idle", req1_ready, 1);
      chk("rr_idle_valid", resp_valid, 0);
      step();
      req1_valid = 1'b0;
      step();
      chk("or_result", resp_result, 7);
      chk("or_id", resp_id, 1);
      chk("or_zero", resp_zero, 0);
      step();
      set_req(0, 1'b1, 4'b0010, 1, 1);
      set_req(1, 1'b1, 4'b0000, 6, 3);
      #1;
      chk("rr2_ready0", req0_ready, 1);
      chk("rr2_ready1", req1_ready, 0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      chk("rr2_result", resp_result, 2);
      step();

      // MUL 3*4 from req1, latency 4
      set_req(1, 1'b1, 4'b0111, 3, 4);
      #1;
      chk("mul_ready1", req1_ready, 1);
      step();
      req1_valid = 1'b0;
      chk("mul_alu_ctrl", alu_ctrl, 4'b0111);
      chk("mul_busy", busy, 1);
      step(); step(); step();
      chk("mul_t4_valid", resp_valid, 0);
      step();
      chk("mul_t5_valid", resp_valid, 1);
      chk("mul_result", resp_result, 12);
      chk("mul_id", resp_id, 1);
      step();

      // Local divide-by-zero, then illegal op; ALU registers keep MUL
      set_req(0, 1'b1, 4'b0100, 9, 0);
      #1;
      chk("dz_ready0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      chk("dz_valid", resp_valid, 1);
      chk("dz_result", resp_result, {W{1'b1}});
      chk("dz_r", resp_r, 9);
      chk("dz_err", resp_err, 1);
      chk("dz_ovf", resp_overflow, 0);
      chk("dz_alu_ctrl", alu_ctrl, 4'b0111);
      step();
      set_req(0, 1'b1, 4'b1111, 5, 5);
      #1;
      chk("ill_ready0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      chk("ill_valid", resp_valid, 1);
      chk("ill_result", resp_result, 0);
      chk("ill_r", resp_r, 0);
      chk("ill_err", resp_err, 1);
      chk("ill_alu_ctrl", alu_ctrl, 4'b0111);
      chk("ill_alu_in1", alu_in1, 3);
      step();

      // Legal DIV 100/7, latency 16
      set_req(0, 1'b1, 4'b0100, 100, 7);
      #1;
      chk("div_ready0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("div_t16_valid", resp_valid, 0);
      step();
      chk("div_t17_valid", resp_valid, 1);
      chk("div_result", resp_result, 14);
      chk("div_r", resp_r, 2);
      chk("div_err", resp_err, 0);
      step();

      // Backpressure: response held while consumer stalls
      resp_ready = 1'b0;
      set_req(0, 1'b1, 4'b0010, 2, 3);
      #1;
      chk("bp_ready0", req0_ready, 1);
      step();
      set_req(0, 1'b1, 4'b0000, 12, 10);
      set_req(1, 1'b1, 4'b0001, 8, 1);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", resp_valid, 1);
         chk("bp_result", resp_result, 5);
         chk("bp_ready0_low", req0_ready, 0);
         chk("bp_ready1_low", req1_ready, 0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      chk("bp_release_ready0", req0_ready, 0);
      chk("bp_release_ready1", req1_ready, 0);
      step();
      chk("bp_idle_valid", resp_valid, 0);
      chk("bp_next_ready1", req1_ready, 1);
      chk("bp_next_ready0", req0_ready, 0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      chk("bp_next_result", resp_result, 9);
      chk("bp_next_id", resp_id, 1);
      step();

      // Reset in the middle of a divide
      set_req(0, 1'b1, 4'b0100, 50, 5);
      #1;
      chk("rdiv_ready0", req0_ready, 1);
      step();
      req0_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_busy", busy, 0);
      chk("mid_valid", resp_valid, 0);
      chk("mid_alu_ctrl", alu_ctrl, 0);
      chk("mid_alu_in1", alu_in1, 0);
      chk("mid_alu_in2", alu_in2, 0);
      stale = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         stale = stale | resp_valid;
      end
      chk("mid_no_stale", stale, 0);
      set_req(1, 1'b1, 4'b0010, 4, 4);
      #1;
      chk("post_ready1", req1_ready, 1);
      step();
      req1_valid = 1'b0;
      step();
      chk("post_valid", resp_valid, 1);
      chk("post_result", resp_result, 8);
      chk("post_id", resp_id, 1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
